// File: rtl/banner_buffer.sv
// banner_buffer: stores a UART-received banner in a two-bank character RAM and scrolls it across
// six 7-segment digit codes. Define BANNER_ECHO_EN to add the one-entry tx echo port.
module banner_buffer #(
  parameter int unsigned TURNS = 25_000_000,
  parameter int unsigned W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  output logic [4:0]   in0,
  output logic [4:0]   in1,
  output logic [4:0]   in2,
  output logic [4:0]   in3,
  output logic [4:0]   in4,
  output logic [4:0]   in5,
  output logic [W:0]   msg_len,
  output logic         overflow
`ifdef BANNER_ECHO_EN
  ,
  output logic         tx_valid,
  output logic [7:0]   tx_data,
  input  logic         tx_ready
`endif
);

  localparam int unsigned CW = (TURNS > 1) ? $clog2(TURNS) : 1;
  // Position width leaves headroom for p + 6 beyond L + 6.
  localparam int unsigned PW = W + 3;
  localparam logic [CW-1:0] CntMax = CW'(TURNS - 1);
  localparam logic [4:0] Blank = 5'd31;

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StFill  = 2'd1;
  localparam logic [1:0] StLoad  = 2'd2;
  localparam logic [1:0] StShow  = 2'd3;

  function automatic logic [4:0] char_code(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return 5'(b - 8'h30);
    if (b >= 8'h41 && b <= 8'h55) return 5'(b - 8'h37);
    if (b >= 8'h61 && b <= 8'h75) return 5'(b - 8'h57);
    return Blank;
  endfunction

  logic [1:0]    state_q, state_d;
  logic          bank_q, bank_d;
  logic [W:0]    wr_ptr_q, wr_ptr_d;
  logic [W:0]    msg_len_q, msg_len_d;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] p_q, p_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    fill_cnt_q, fill_cnt_d;
  logic [24:0]   shadow_q, shadow_d;
  logic [29:0]   disp_q, disp_d;
  logic          shift_pend_q, shift_pend_d;
  logic          rd_blank_q;
  logic [4:0]    rd_q;

  logic          is_term, is_bs, is_char, commit, wr_en, scroll, rd_blank;
  logic [W:0]    wr_addr, rd_addr;
  logic [PW-1:0] len_ext, period, p_inc, p_next, shift_sum, shift_pos, rd_pos;
  logic [4:0]    rd_val;

  logic [4:0] mem [0:(2**(W+1))-1];

  assign is_term = rx_valid && (rx_data == 8'h0D || rx_data == 8'h0A);
  assign is_bs   = rx_valid && (rx_data == 8'h08);
  assign is_char = rx_valid && (rx_data >= 8'h20);
  assign commit  = is_term && (wr_ptr_q != '0);
  // Staging always targets the inactive bank; the MSB of wr_ptr marks a full line.
  assign wr_en   = is_char && !wr_ptr_q[W];
  assign wr_addr = {~bank_q, wr_ptr_q[W-1:0]};

  assign len_ext   = PW'(msg_len_q);
  assign period    = len_ext + PW'(6);
  assign scroll    = len_ext > PW'(6);
  assign p_inc     = p_q + PW'(1);
  assign p_next    = (p_inc == period) ? '0 : p_inc;
  assign shift_sum = p_q + PW'(6);
  assign shift_pos = (shift_sum >= period) ? shift_sum - period : shift_sum;
  assign rd_pos    = (state_q == StFill) ? PW'(fill_cnt_q) : shift_pos;
  assign rd_blank  = rd_pos >= len_ext;
  assign rd_addr   = {bank_q, rd_pos[W-1:0]};
  assign rd_val    = rd_blank_q ? Blank : rd_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= char_code(rx_data);
    rd_q <= mem[rd_addr];
  end

  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    wr_ptr_d     = wr_ptr_q;
    msg_len_d    = msg_len_q;
    overflow_d   = overflow_q;
    p_d          = p_q;
    cnt_d        = cnt_q;
    fill_cnt_d   = fill_cnt_q;
    shadow_d     = shadow_q;
    disp_d       = disp_q;
    shift_pend_d = shift_pend_q;
    if (commit) begin
      // A commit pre-empts any fill, pending shift or coincident tick.
      bank_d       = ~bank_q;
      msg_len_d    = wr_ptr_q;
      wr_ptr_d     = '0;
      overflow_d   = 1'b0;
      p_d          = '0;
      cnt_d        = '0;
      fill_cnt_d   = '0;
      shift_pend_d = 1'b0;
      state_d      = StFill;
    end else begin
      if (is_bs) begin
        if (wr_ptr_q != '0) wr_ptr_d = wr_ptr_q - 1'b1;
      end else if (is_char) begin
        if (wr_ptr_q[W]) overflow_d = 1'b1;
        else             wr_ptr_d   = wr_ptr_q + 1'b1;
      end
      case (state_q)
        StFill: begin
          // Six shifts leave positions 0..4 here; position 5 is still in rd_q.
          shadow_d   = {shadow_q[19:0], rd_val};
          fill_cnt_d = fill_cnt_q + 3'd1;
          if (fill_cnt_q == 3'd5) state_d = StLoad;
        end
        StLoad: begin
          disp_d  = {shadow_q, rd_val};
          state_d = StShow;
        end
        StShow: begin
          if (shift_pend_q) begin
            disp_d       = {disp_q[24:0], rd_val};
            shift_pend_d = 1'b0;
          end
          if (scroll) begin
            if (cnt_q == CntMax) begin
              cnt_d        = '0;
              p_d          = p_next;
              shift_pend_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StEmpty;
      bank_q       <= 1'b0;
      wr_ptr_q     <= '0;
      msg_len_q    <= '0;
      overflow_q   <= 1'b0;
      p_q          <= '0;
      cnt_q        <= '0;
      fill_cnt_q   <= '0;
      shadow_q     <= {5{Blank}};
      disp_q       <= {6{Blank}};
      shift_pend_q <= 1'b0;
      rd_blank_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      wr_ptr_q     <= wr_ptr_d;
      msg_len_q    <= msg_len_d;
      overflow_q   <= overflow_d;
      p_q          <= p_d;
      cnt_q        <= cnt_d;
      fill_cnt_q   <= fill_cnt_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      shift_pend_q <= shift_pend_d;
      rd_blank_q   <= rd_blank;
    end
  end

  assign in5      = disp_q[29:25];
  assign in4      = disp_q[24:20];
  assign in3      = disp_q[19:15];
  assign in2      = disp_q[14:10];
  assign in1      = disp_q[9:5];
  assign in0      = disp_q[4:0];
  assign msg_len  = msg_len_q;
  assign overflow = overflow_q;

`ifdef BANNER_ECHO_EN
  logic       tx_valid_q;
  logic [7:0] tx_data_q;

  // A byte arriving while the holding register is full (even during its handshake) is not echoed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else if (tx_valid_q && tx_ready) begin
      tx_valid_q <= 1'b0;
    end else if (rx_valid && !tx_valid_q) begin
      tx_valid_q <= 1'b1;
      tx_data_q  <= rx_data;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
`endif

endmodule

// File: tb/tb_banner_buffer.sv
// Bench for banner_buffer: a cycle-indexed reference model queues every expected output change;
// a negedge monitor pops and compares whenever the DUT outputs change.
module tb_banner_buffer;
  localparam int TURNS = 8;
  localparam int W     = 3;
  localparam int DEPTH = 1 << W;
  localparam logic [29:0] ALL31 = {6{5'd31}};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [4:0] in0, in1, in2, in3, in4, in5;
  logic [W:0] msg_len;
  logic       overflow;
`ifdef BANNER_ECHO_EN
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b0;
`endif

  banner_buffer #(.TURNS(TURNS), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .in4      (in4),
    .in5      (in5),
    .msg_len  (msg_len),
    .overflow (overflow)
`ifdef BANNER_ECHO_EN
    ,
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [29:0] win;
    int          len;
    bit          ovf;
  } snap_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  snap_t exp_q[$];

  // Reference model state: lines as queues of character codes.
  int          stage[$];
  int          msg[$];
  int          m_len = 0;
  bit          m_ovf = 0;
  bit          m_have = 0;
  int          ce = 0;
  logic [29:0] frozen = ALL31;
  logic [29:0] m_win = ALL31;
  int          s_len = 0;
  bit          s_ovf = 0;

  function automatic int ref_code(logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "U") return int'(b) - 65 + 10;
    if (b >= "a" && b <= "u") return int'(b) - 97 + 10;
    return 31;
  endfunction

  function automatic logic [29:0] win_at(int p);
    logic [29:0] w;
    int idx;
    for (int i = 0; i < 6; i++) begin
      idx = (p + i) % (m_len + 6);
      w[29-5*i -: 5] = (idx < m_len) ? 5'(msg[idx]) : 5'd31;
    end
    return w;
  endfunction

  // Load shows at ce+7; the j-th scroll step shows at ce+8+j*TURNS; before the load the old view holds.
  function automatic logic [29:0] expect_win(int n);
    int steps;
    if (!m_have) return ALL31;
    if (n < ce + 7) return frozen;
    steps = (n - ce - 8 >= TURNS) ? (n - ce - 8) / TURNS : 0;
    if (m_len <= 6) steps = 0;
    return win_at(steps % (m_len + 6));
  endfunction

  function automatic void model_byte(logic [7:0] b);
    if (b == 8'h0D || b == 8'h0A) begin
      if (stage.size() > 0) begin
        msg    = stage;
        m_len  = stage.size();
        stage.delete();
        m_ovf  = 0;
        m_have = 1;
        ce     = cyc;
        frozen = m_win;
      end
    end else if (b == 8'h08) begin
      if (stage.size() > 0) void'(stage.pop_back());
    end else if (b >= 8'h20) begin
      if (stage.size() == DEPTH) m_ovf = 1;
      else stage.push_back(ref_code(b));
    end
  endfunction

  always @(posedge clk) begin : model
    snap_t s;
    logic [29:0] w;
    cyc++;
    if (rst) begin
      stage.delete();
      msg.delete();
      m_len = 0; m_ovf = 0; m_have = 0;
      m_win = ALL31; s_len = 0; s_ovf = 0;
      exp_q.delete();
    end else begin
      if (rx_valid) model_byte(rx_data);
      w = expect_win(cyc);
      if (w != m_win || m_len != s_len || m_ovf != s_ovf) begin
        s.cyc = cyc; s.win = w; s.len = m_len; s.ovf = m_ovf;
        exp_q.push_back(s);
        m_win = w; s_len = m_len; s_ovf = m_ovf;
      end
    end
  end

  logic [29:0] p_win = ALL31;
  int          p_len = 0;
  bit          p_ovf = 0;

  always @(negedge clk) begin : monitor
    logic [29:0] dw;
    snap_t e;
    dw = {in5, in4, in3, in2, in1, in0};
    if (rst) begin
      p_win = ALL31; p_len = 0; p_ovf = 0;
    end else begin
      if (dw != p_win || int'(msg_len) != p_len || overflow != p_ovf) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got win=%h len=%0d ovf=%0b, required no change",
                   cyc, dw, msg_len, overflow);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.win != dw || e.len != int'(msg_len) || e.ovf != overflow) begin
            errors++;
            $display("FAIL output_change got cyc=%0d win=%h len=%0d ovf=%0b, required cyc=%0d win=%h len=%0d ovf=%0b",
                     cyc, dw, msg_len, overflow, e.cyc, e.win, e.len, e.ovf);
          end
        end
        p_win = dw; p_len = int'(msg_len); p_ovf = overflow;
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_change got no change by cyc=%0d, required win=%h len=%0d ovf=%0b at cyc=%0d",
                 cyc, exp_q[0].win, exp_q[0].len, exp_q[0].ovf, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic check(string name, logic [63:0] got, logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  initial begin
    int r;
    int g;
    logic [7:0] b;
    logic [29:0] hold;

    idle(2);
    check("reset_win", {in5, in4, in3, in2, in1, in0}, ALL31);
    check("reset_msg_len", msg_len, 0);
    check("reset_overflow", overflow, 0);
    rst = 1'b0;
    idle(3 * TURNS);
    check("idle_win", {in5, in4, in3, in2, in1, in0}, ALL31);

`ifdef BANNER_ECHO_EN
    check("echo_reset_valid", tx_valid, 0);
    send("A");
    send("B");
    check("echo_valid_held", tx_valid, 1);
    check("echo_first_byte", tx_data, 8'h41);
    idle(2);
    check("echo_no_overwrite", tx_data, 8'h41);
    tx_ready = 1'b1;
    idle(1);
    tx_ready = 1'b0;
    check("echo_drop", tx_valid, 0);
    send(8'h08);
    send(8'h08);
`endif

    send_str("HI12");
    send(8'h0D);
    check("hi12_msg_len", msg_len, 4);
    idle(7);
    check("hi12_win", {in5, in4, in3, in2, in1, in0},
          {5'd17, 5'd18, 5'd1, 5'd2, 5'd31, 5'd31});
    idle(3 * TURNS);
    check("hi12_static", {in5, in4, in3, in2, in1, in0},
          {5'd17, 5'd18, 5'd1, 5'd2, 5'd31, 5'd31});

    send_str("ABCDEFG");
    send(8'h0A);
    idle(7);
    check("scroll_initial", {in5, in4, in3, in2, in1, in0},
          {5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15});
    idle(TURNS + 1);
    check("scroll_first_tick", {in5, in4, in3, in2, in1, in0},
          {5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16});
    idle(12 * TURNS);
    check("scroll_wrap", {in5, in4, in3, in2, in1, in0},
          {5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15});

    idle(3);
    rst = 1'b1;
    #1;
    check("midop_reset_win", {in5, in4, in3, in2, in1, in0}, ALL31);
    check("midop_reset_len", msg_len, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    send_str("ABCDEFGH");
    check("no_overflow_at_full", overflow, 0);
    send("I");
    check("overflow_set", overflow, 1);
    send("J");
    send(8'h0D);
    check("overflow_msg_len", msg_len, DEPTH);
    check("overflow_cleared", overflow, 0);
    idle(7);
    check("overflow_win", {in5, in4, in3, in2, in1, in0},
          {5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15});

    send_str("AB");
    send(8'h08);
    send("C");
    send(8'h0D);
    idle(7);
    hold = {in5, in4, in3, in2, in1, in0};
    check("backspace_win", hold, {5'd10, 5'd12, 5'd31, 5'd31, 5'd31, 5'd31});
    send(8'h0D);
    idle(10);
    check("lone_term_win", {in5, in4, in3, in2, in1, in0},
          {5'd10, 5'd12, 5'd31, 5'd31, 5'd31, 5'd31});
    check("lone_term_len", msg_len, 2);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      b = 8'($urandom_range(32, 126));
      else if (r < 65) b = 8'($urandom_range(0, 255));
      else if (r < 75) b = 8'h08;
      else if (r < 88) b = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
      else             b = 8'($urandom_range(48, 57));
      send(b);
      g = $urandom_range(0, 9);
      if (g >= 8)      idle($urandom_range(5, 12 * TURNS));
      else if (g >= 4) idle($urandom_range(1, 3));
    end

    idle(20);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
